// File: rtl/ysyx_22040127_mulctl_pkg.sv
// Shared types and helpers for the RV64M multiplier sequencing controller.
package ysyx_22040127_mulctl_pkg;

    localparam int unsigned MUL_XLEN = 64;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WAIT  = 2'b01,
        S_HOLD  = 2'b10,
        S_DRAIN = 2'b11
    } state_e;

    // One cached product together with the operands and signedness that made it.
    typedef struct packed {
        logic [MUL_XLEN-1:0] src1;
        logic [MUL_XLEN-1:0] src2;
        logic                xs;
        logic                ys;
        logic [MUL_XLEN-1:0] high;
        logic [MUL_XLEN-1:0] low;
    } cache_entry_t;

    // Operand signedness {xs, ys}; MUL/MULW use signed, low half is sign-agnostic anyway.
    function automatic logic [1:0] op_signs(input mul_op_e op);
        case (op)
            OP_MULHSU: return 2'b10;
            OP_MULHU:  return 2'b00;
            default:   return 2'b11;
        endcase
    endfunction

    // Pick the architectural result from a 128-bit product.
    function automatic logic [MUL_XLEN-1:0] sel_result(input mul_op_e op, input logic word,
                                                       input logic [MUL_XLEN-1:0] high,
                                                       input logic [MUL_XLEN-1:0] low);
        if (op == OP_MUL) begin
            if (word) return {{(MUL_XLEN-32){low[31]}}, low[31:0]};
            return low;
        end
        return high;
    endfunction

endpackage

// File: rtl/ysyx_22040127_mulctl_cache.sv
// One-entry operand-reuse cache: stores the last completed product and its tag.
module ysyx_22040127_mulctl_cache
    import ysyx_22040127_mulctl_pkg::*;
#(
    parameter bit REUSE_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MUL_XLEN-1:0] q_src1_i,
    input  logic [MUL_XLEN-1:0] q_src2_i,
    input  mul_op_e             q_op_i,
    input  logic                q_xs_i,
    input  logic                q_ys_i,
    input  logic                we_i,
    input  cache_entry_t        w_entry_i,
    output logic                hit_c_o,
    output logic [MUL_XLEN-1:0] high_o,
    output logic [MUL_XLEN-1:0] low_o
);

    logic         valid_q;
    cache_entry_t entry_q;

    // Entry storage; only reset clears it since a product depends solely on its operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else if (we_i) begin
            valid_q <= 1'b1;
            entry_q <= w_entry_i;
        end
    end

    // Tag compare; a plain MUL hits regardless of signedness because the low half is identical.
    always_comb begin
        hit_c_o = REUSE_EN && valid_q
                  && (q_src1_i == entry_q.src1) && (q_src2_i == entry_q.src2)
                  && ((q_op_i == OP_MUL) || ({q_xs_i, q_ys_i} == {entry_q.xs, entry_q.ys}));
    end

    assign high_o = entry_q.high;
    assign low_o  = entry_q.low;

endmodule

// File: rtl/ysyx_22040127_mulctl.sv
// Sequencing controller between the EXU and the 2-stage 64x64 multiplier.
module ysyx_22040127_mulctl
    import ysyx_22040127_mulctl_pkg::*;
#(
    parameter int unsigned XLEN     = MUL_XLEN,
    parameter bit          REUSE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [XLEN-1:0] mul_x,
    output logic [XLEN-1:0] mul_y,
    output logic            mul_xs,
    output logic            mul_ys,
    output logic            mul_type,
    input  logic [XLEN-1:0] mul_high,
    input  logic [XLEN-1:0] mul_low,
    input  logic            mul_ok
);

    state_e          state_q, state_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    mul_op_e         lat_op_q, lat_op_d;
    logic            lat_word_q, lat_word_d;
    logic [XLEN-1:0] lat_src1_q, lat_src1_d;
    logic [XLEN-1:0] lat_src2_q, lat_src2_d;
    logic            lat_xs_q, lat_xs_d;
    logic            lat_ys_q, lat_ys_d;

    mul_op_e         req_op_c;
    logic            accept_c;
    logic            hit_c;
    logic            cache_we_c;
    cache_entry_t    cache_wr_c;
    logic [XLEN-1:0] c_high, c_low;

    // Request decode and handshake; operands go straight to the multiplier.
    assign req_op_c          = mul_op_e'(in_op);
    assign {mul_xs, mul_ys}  = op_signs(req_op_c);
    assign mul_x             = in_src1;
    assign mul_y             = in_src2;
    assign in_ready          = !flush && ((state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready));
    assign accept_c          = in_valid && in_ready;

    // Cache fill payload comes from the request latched at accept time.
    always_comb begin
        cache_wr_c      = '0;
        cache_wr_c.src1 = lat_src1_q;
        cache_wr_c.src2 = lat_src2_q;
        cache_wr_c.xs   = lat_xs_q;
        cache_wr_c.ys   = lat_ys_q;
        cache_wr_c.high = mul_high;
        cache_wr_c.low  = mul_low;
    end

    ysyx_22040127_mulctl_cache #(
        .REUSE_EN (REUSE_EN)
    ) u_cache (
        .clk       (clk),
        .rst       (rst),
        .q_src1_i  (in_src1),
        .q_src2_i  (in_src2),
        .q_op_i    (req_op_c),
        .q_xs_i    (mul_xs),
        .q_ys_i    (mul_ys),
        .we_i      (cache_we_c),
        .w_entry_i (cache_wr_c),
        .hit_c_o   (hit_c),
        .high_o    (c_high),
        .low_o     (c_low)
    );

    // Next-state and datapath control; an accept (only legal in IDLE/HOLD) overrides the per-state move.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        lat_op_d    = lat_op_q;
        lat_word_d  = lat_word_q;
        lat_src1_d  = lat_src1_q;
        lat_src2_d  = lat_src2_q;
        lat_xs_d    = lat_xs_q;
        lat_ys_d    = lat_ys_q;
        mul_type    = 1'b0;
        cache_we_c  = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (mul_ok) begin
                    state_d = S_IDLE;
                    if (!flush) begin
                        out_data_d  = sel_result(lat_op_q, lat_word_q, mul_high, mul_low);
                        out_valid_d = 1'b1;
                        cache_we_c  = 1'b1;
                        state_d     = S_HOLD;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (flush || out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (mul_ok) state_d = S_IDLE;
            end
            default: ;
        endcase

        if (accept_c) begin
            if (hit_c) begin
                out_data_d  = sel_result(req_op_c, in_word, c_high, c_low);
                out_valid_d = 1'b1;
                state_d     = S_HOLD;
            end else begin
                mul_type    = 1'b1;
                lat_op_d    = req_op_c;
                lat_word_d  = in_word;
                lat_src1_d  = in_src1;
                lat_src2_d  = in_src2;
                lat_xs_d    = mul_xs;
                lat_ys_d    = mul_ys;
                state_d     = S_WAIT;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            lat_op_q    <= OP_MUL;
            lat_word_q  <= 1'b0;
            lat_src1_q  <= '0;
            lat_src2_q  <= '0;
            lat_xs_q    <= 1'b0;
            lat_ys_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            lat_op_q    <= lat_op_d;
            lat_word_q  <= lat_word_d;
            lat_src1_q  <= lat_src1_d;
            lat_src2_q  <= lat_src2_d;
            lat_xs_q    <= lat_xs_d;
            lat_ys_q    <= lat_ys_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_ysyx_22040127_mulctl.sv
// Directed bench: two controllers (reuse on / reuse off), each with a 2-stage multiplier model.
module tb_ysyx_22040127_mulctl;
    import ysyx_22040127_mulctl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, sel, in_valid, in_word, flush, out_ready;
    logic [1:0]  in_op;
    logic [63:0] in_src1, in_src2;

    logic [1:0]       rdy, ov, mt, xs, ys, mok;
    logic [1:0][63:0] od, mx, my, mh, ml;

    int n_vec = 0;
    int n_err = 0;
    int proto_err = 0;

    localparam logic [63:0] M3   = 64'hFFFF_FFFF_FFFF_FFFD;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    ysyx_22040127_mulctl #(.REUSE_EN(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(rdy[0]),
        .in_op(in_op), .in_word(in_word), .in_src1(in_src1), .in_src2(in_src2),
        .flush(flush), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
        .mul_x(mx[0]), .mul_y(my[0]), .mul_xs(xs[0]), .mul_ys(ys[0]), .mul_type(mt[0]),
        .mul_high(mh[0]), .mul_low(ml[0]), .mul_ok(mok[0])
    );

    ysyx_22040127_mulctl #(.REUSE_EN(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(rdy[1]),
        .in_op(in_op), .in_word(in_word), .in_src1(in_src1), .in_src2(in_src2),
        .flush(flush), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
        .mul_x(mx[1]), .mul_y(my[1]), .mul_xs(xs[1]), .mul_ys(ys[1]), .mul_type(mt[1]),
        .mul_high(mh[1]), .mul_low(ml[1]), .mul_ok(mok[1])
    );

    function automatic logic [127:0] prod(input logic [63:0] x, input logic [63:0] y,
                                          input logic sx, input logic sy);
        logic [127:0] ex, ey;
        ex = sx ? {{64{x[63]}}, x} : {64'd0, x};
        ey = sy ? {{64{y[63]}}, y} : {64'd0, y};
        return ex * ey;
    endfunction

    // Multiplier model: product valid two cycles after the start pulse.
    for (genvar g = 0; g < 2; g++) begin : g_mul
        logic         v1, v2;
        logic [127:0] p1, p2;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v1 <= 1'b0; v2 <= 1'b0; p1 <= '0; p2 <= '0;
            end else begin
                v1 <= mt[g];
                p1 <= prod(mx[g], my[g], xs[g], ys[g]);
                v2 <= v1;
                p2 <= p1;
            end
        end
        assign mok[g] = v2;
        assign mh[g]  = p2[127:64];
        assign ml[g]  = p2[63:0];
    end

    // Protocol watch: mul_ok only in WAIT/DRAIN, start pulse never there.
    always @(negedge clk) begin
        if (mok[0] && !(u_dut0.state_q inside {S_WAIT, S_DRAIN})) proto_err++;
        if (mok[1] && !(u_dut1.state_q inside {S_WAIT, S_DRAIN})) proto_err++;
        if (mt[0] && (u_dut0.state_q inside {S_WAIT, S_DRAIN})) proto_err++;
        if (mt[1] && (u_dut1.state_q inside {S_WAIT, S_DRAIN})) proto_err++;
    end

    logic        o_rdy, o_ov, o_mt, o_xs, o_ys;
    logic [63:0] o_od;
    assign o_rdy = rdy[sel];
    assign o_ov  = ov[sel];
    assign o_mt  = mt[sel];
    assign o_xs  = xs[sel];
    assign o_ys  = ys[sel];
    assign o_od  = od[sel];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a request (caller sits at a negedge) and let it be accepted at the next posedge.
    task automatic send(input logic [1:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic mt_exp, input logic [1:0] sgn_exp);
        int n;
        in_valid = 1'b1; in_op = op; in_word = w; in_src1 = a; in_src2 = b;
        #1;
        n = 0;
        while (!o_rdy && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("accept_wait", 64'(n >= 20), 64'd0);
        check("mul_type", 64'(o_mt), 64'(mt_exp));
        check("signs", 64'({o_xs, o_ys}), 64'(sgn_exp));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge until out_valid; ends at that negedge.
    task automatic wait_result(input int exp_lat, input logic [63:0] exp_data);
        int lat;
        lat = 0;
        do begin
            @(negedge clk); lat++;
        end while (!o_ov && lat < 20);
        check("latency", 64'(lat), 64'(exp_lat));
        check("data", o_od, exp_data);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_word = 1'b0;
        in_src1 = '0; in_src2 = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(o_ov), 64'd0);
        check("rst_out_data", o_od, 64'd0);
        check("rst_in_ready", 64'(o_rdy), 64'd1);
        check("rst_mul_type", 64'(o_mt), 64'd0);
        @(negedge clk);

        // MULH -3*5 miss, then MUL same operands hits
        send(OP_MULH, 1'b0, M3, 64'd5, 1'b1, 2'b11);
        wait_result(3, ONES);
        send(OP_MUL, 1'b0, M3, 64'd5, 1'b0, 2'b11);
        wait_result(1, 64'hFFFF_FFFF_FFFF_FFF1);

        // MULHU all-ones squared, then MULHSU must miss on signedness
        send(OP_MULHU, 1'b0, ONES, ONES, 1'b1, 2'b00);
        wait_result(3, 64'hFFFF_FFFF_FFFF_FFFE);
        send(OP_MULHSU, 1'b0, ONES, ONES, 1'b1, 2'b10);
        wait_result(3, ONES);

        // MULW sign-extension, miss then hit
        send(OP_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 1'b1, 2'b11);
        wait_result(3, 64'hFFFF_FFFF_FFFF_FFFE);
        send(OP_MUL, 1'b1, 64'h7FFF_FFFF, 64'd2, 1'b0, 2'b11);
        wait_result(1, 64'hFFFF_FFFF_FFFF_FFFE);

        // Back-pressure in HOLD, then back-to-back accept
        send(OP_MUL, 1'b0, 64'd3, 64'd4, 1'b1, 2'b11);
        out_ready = 1'b0;
        wait_result(3, 64'd12);
        in_valid = 1'b1; in_op = OP_MULHU; in_word = 1'b0;
        in_src1 = 64'h8000_0000_0000_0000; in_src2 = 64'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("hold_data", o_od, 64'd12);
            check("hold_valid", 64'(o_ov), 64'd1);
            check("hold_in_ready", 64'(o_rdy), 64'd0);
        end
        out_ready = 1'b1;
        send(OP_MULHU, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 1'b1, 2'b00);
        wait_result(3, 64'd2);

        // Flush one cycle after accept -> DRAIN, nothing cached
        send(OP_MUL, 1'b0, 64'd7, 64'd9, 1'b1, 2'b11);
        @(negedge clk); flush = 1'b1; #1;
        check("flush_in_ready", 64'(o_rdy), 64'd0);
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk); #1;
        check("drain_in_ready", 64'(o_rdy), 64'd0);
        check("drain_out_valid", 64'(o_ov), 64'd0);
        @(negedge clk); #1;
        check("post_drain_ready", 64'(o_rdy), 64'd1);
        check("post_drain_valid", 64'(o_ov), 64'd0);
        send(OP_MUL, 1'b0, 64'd7, 64'd9, 1'b1, 2'b11);
        wait_result(3, 64'd63);

        // Flush coinciding with mul_ok -> IDLE, result discarded
        send(OP_MUL, 1'b0, 64'd11, 64'd13, 1'b1, 2'b11);
        @(negedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk); #1;
        check("flushok_valid", 64'(o_ov), 64'd0);
        check("flushok_ready", 64'(o_rdy), 64'd1);
        send(OP_MUL, 1'b0, 64'd11, 64'd13, 1'b1, 2'b11);
        wait_result(3, 64'd143);

        // Async reset mid-WAIT clears state and cache
        send(OP_MUL, 1'b0, 64'd5, 64'd5, 1'b1, 2'b11);
        @(negedge clk); rst = 1'b1; #1;
        check("arst_out_valid", 64'(o_ov), 64'd0);
        check("arst_out_data", o_od, 64'd0);
        check("arst_in_ready", 64'(o_rdy), 64'd1);
        @(negedge clk); rst = 1'b0;
        send(OP_MUL, 1'b0, 64'd11, 64'd13, 1'b1, 2'b11);
        wait_result(3, 64'd143);

        // Reuse disabled: repeat request always goes to the multiplier
        @(negedge clk); sel = 1'b1;
        send(OP_MULH, 1'b0, M3, 64'd5, 1'b1, 2'b11);
        wait_result(3, ONES);
        send(OP_MUL, 1'b0, M3, 64'd5, 1'b1, 2'b11);
        wait_result(3, 64'hFFFF_FFFF_FFFF_FFF1);

        repeat (3) @(negedge clk);
        check("protocol", 64'(proto_err), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
